// File: rtl/riscv_dm_pkg.sv
// Shared types for the SRI to AXI-lite bridge: FSM states and AXI response codes.
package riscv_dm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RESP  = 3'd5
  } sri_state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic resp_err(input logic [1:0] resp);
    return resp != OKAY;
  endfunction

endpackage

// File: rtl/sri_to_axilite.sv
// Single-outstanding SRI slave to AXI-lite master bridge.
// Define SRI_TO_AXILITE_TIMEOUT_EN to abort stalled transactions.
module sri_to_axilite
  import riscv_dm_pkg::*;
#(
  parameter int unsigned SRI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,

  input  logic                      sri_en_i,
  input  logic                      sri_we_i,
  input  logic [SRI_ADDR_WIDTH-1:0] sri_addr_i,
  input  logic [DATA_WIDTH-1:0]     sri_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   sri_be_i,
  output logic                      sri_busy_o,
  output logic                      sri_rvalid_o,
  output logic [DATA_WIDTH-1:0]     sri_rdata_o,
  output logic                      sri_error_o,

  output logic [AXI_ADDR_WIDTH-1:0] m_awaddr_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_araddr_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);

  localparam int unsigned BE_W = DATA_WIDTH / 8;

  sri_state_e                state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [BE_W-1:0]           be_q, be_d;
  logic                      awvalid_q, awvalid_d;
  logic                      wvalid_q, wvalid_d;
  logic                      arvalid_q, arvalid_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_ext;
  logic                      aw_done;
  logic                      w_done;

`ifdef SRI_TO_AXILITE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tmo;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    addr_ext = '0;
    addr_ext[SRI_ADDR_WIDTH-1:0] = sri_addr_i;
  end

  // A channel is done once its valid has dropped or handshakes now
  assign aw_done = !awvalid_q || m_awready_i;
  assign w_done  = !wvalid_q || m_wready_i;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (sri_en_i) begin
          addr_d  = BASE_ADDR + addr_ext;
          wdata_d = sri_wdata_i;
          be_d    = sri_be_i;
          if (sri_we_i) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WRITE;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WRITE: begin
        if (awvalid_q && m_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && m_wready_i)   wvalid_d  = 1'b0;
        if (aw_done && w_done)        state_d   = WRESP;
      end
      WRESP: begin
        if (m_bvalid_i) begin
          rdata_d = '0;
          err_d   = resp_err(m_bresp_i);
          state_d = RESP;
        end
      end
      RADDR: begin
        if (m_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_rvalid_i) begin
          rdata_d = m_rdata_i;
          err_d   = resp_err(m_rresp_i);
          state_d = RESP;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef SRI_TO_AXILITE_TIMEOUT_EN
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + 1'b1;
    tmo   = (state_q != IDLE) && (state_q != RESP) &&
            (cnt_d == CW'(TIMEOUT_CYCLES));
    // Abort overrides whatever the channel logic decided
    if (tmo) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rdata_d   = '0;
      err_d     = 1'b1;
      state_d   = RESP;
    end
`endif
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

`ifdef SRI_TO_AXILITE_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`endif

  assign sri_busy_o   = state_q != IDLE;
  assign sri_rvalid_o = state_q == RESP;
  assign sri_rdata_o  = rdata_q;
  assign sri_error_o  = err_q;

  assign m_awaddr_o  = addr_q;
  assign m_awvalid_o = awvalid_q;
  assign m_wdata_o   = wdata_q;
  assign m_wstrb_o   = be_q;
  assign m_wvalid_o  = wvalid_q;
  assign m_bready_o  = state_q == WRESP;
  assign m_araddr_o  = addr_q;
  assign m_arvalid_o = arvalid_q;
  assign m_rready_o  = state_q == RDATA;

endmodule

// File: tb/tb_sri_to_axilite.sv
// Directed bench for sri_to_axilite; two instances differ only in BASE_ADDR.
// Timeout scenario is exercised when SRI_TO_AXILITE_TIMEOUT_EN is defined.
module tb_sri_to_axilite;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0, we = 1'b0;
  logic [19:0] addr = '0;
  logic [63:0] wdata = '0;
  logic [7:0]  be = '0;
  logic        awready = 1'b0, wready = 1'b0, bvalid = 1'b0;
  logic        arready = 1'b0, rvalid = 1'b0;
  logic [1:0]  bresp = 2'b00, rresp = 2'b00;
  logic [63:0] rdata = '0;

  logic        busy, rv, err, awvalid, wvalid, bready, arvalid, rready;
  logic [63:0] srdata, awdata;
  logic [7:0]  wstrb;
  logic [31:0] awaddr, araddr;

  logic        b_busy, b_rv, b_err, b_awvalid, b_wvalid, b_bready;
  logic        b_arvalid, b_rready;
  logic [63:0] b_srdata, b_awdata;
  logic [7:0]  b_wstrb;
  logic [31:0] b_awaddr, b_araddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sri_to_axilite #(
    .BASE_ADDR(32'h8000_0000), .TIMEOUT_CYCLES(16)
  ) u_dut (
    .clk_i(clk), .rstn_i(rstn),
    .sri_en_i(en), .sri_we_i(we), .sri_addr_i(addr),
    .sri_wdata_i(wdata), .sri_be_i(be),
    .sri_busy_o(busy), .sri_rvalid_o(rv),
    .sri_rdata_o(srdata), .sri_error_o(err),
    .m_awaddr_o(awaddr), .m_awvalid_o(awvalid), .m_awready_i(awready),
    .m_wdata_o(awdata), .m_wstrb_o(wstrb), .m_wvalid_o(wvalid),
    .m_wready_i(wready),
    .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(bready),
    .m_araddr_o(araddr), .m_arvalid_o(arvalid), .m_arready_i(arready),
    .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid),
    .m_rready_o(rready)
  );

  sri_to_axilite #(
    .BASE_ADDR(32'hFFFF_FFF8), .TIMEOUT_CYCLES(16)
  ) u_wrap (
    .clk_i(clk), .rstn_i(rstn),
    .sri_en_i(en), .sri_we_i(we), .sri_addr_i(addr),
    .sri_wdata_i(wdata), .sri_be_i(be),
    .sri_busy_o(b_busy), .sri_rvalid_o(b_rv),
    .sri_rdata_o(b_srdata), .sri_error_o(b_err),
    .m_awaddr_o(b_awaddr), .m_awvalid_o(b_awvalid), .m_awready_i(awready),
    .m_wdata_o(b_awdata), .m_wstrb_o(b_wstrb), .m_wvalid_o(b_wvalid),
    .m_wready_i(wready),
    .m_bresp_i(bresp), .m_bvalid_i(bvalid), .m_bready_o(b_bready),
    .m_araddr_o(b_araddr), .m_arvalid_o(b_arvalid), .m_arready_i(arready),
    .m_rdata_i(rdata), .m_rresp_i(rresp), .m_rvalid_i(rvalid),
    .m_rready_o(b_rready)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{busy, rv, err, srdata, awaddr, awvalid, awdata, wstrb,
             wvalid, bready, araddr, arvalid, rready};
  endfunction

  int bready_cycles;
  int n;
  logic seen;

  initial begin
    #12;
    chk("rst_outputs", any_out(), 1'b0);
    rstn = 1'b1;
    tick();

    // Zero-wait write
    en = 1; we = 1; addr = 20'h10;
    wdata = 64'hDEADBEEF_CAFEF00D; be = 8'hFF;
    awready = 1; wready = 1; bvalid = 1; bresp = 2'b00;
    tick();
    en = 0;
    chk("wr_awvalid", awvalid, 1'b1);
    chk("wr_wvalid", wvalid, 1'b1);
    chk("wr_awaddr", awaddr, 32'h8000_0010);
    chk("wr_wdata", awdata, 64'hDEADBEEF_CAFEF00D);
    chk("wr_wstrb", wstrb, 8'hFF);
    chk("wr_rv_c1", rv, 1'b0);
    tick();
    chk("wr_bready", {awvalid, wvalid, bready}, 3'b001);
    chk("wr_rv_c2", rv, 1'b0);
    tick();
    chk("wr_rv_c3", rv, 1'b1);
    chk("wr_err", err, 1'b0);
    chk("wr_rdata0", srdata, 64'h0);
    awready = 0; wready = 0; bvalid = 0;
    tick();
    chk("wr_rv_pulse", {rv, busy}, 2'b00);

    // Read with arready delayed, plus a request while busy
    en = 1; we = 0; addr = 20'h10;
    tick();
    chk("rd_arvalid", arvalid, 1'b1);
    chk("rd_araddr", araddr, 32'h8000_0010);
    chk("rd_wrap_araddr", b_araddr, 32'h0000_0008);
    en = 1; we = 1; addr = 20'h44;
    tick();
    en = 0; we = 0;
    chk("busy_ignore", {arvalid, awvalid, wvalid}, 3'b100);
    chk("busy_addr", araddr, 32'h8000_0010);
    for (int i = 0; i < 3; i++) tick();
    chk("rd_arvalid_hold", {arvalid, rready}, 2'b10);
    arready = 1;
    tick();
    arready = 0;
    chk("rd_rready", {arvalid, rready}, 2'b01);
    rvalid = 1; rdata = 64'h1234; rresp = 2'b00;
    tick();
    rvalid = 0; rdata = '0;
    chk("rd_rv", rv, 1'b1);
    chk("rd_rdata", srdata, 64'h1234);
    chk("rd_err", err, 1'b0);
    tick();
    chk("rd_rv_pulse", rv, 1'b0);
    chk("rd_rdata_hold", srdata, 64'h1234);

    // Write: awready first cycle, wready later, SLVERR
    en = 1; we = 1; addr = 20'h20; wdata = 64'h55; be = 8'h0F;
    awready = 1;
    tick();
    en = 0;
    chk("ww_both_valid", {awvalid, wvalid}, 2'b11);
    chk("ww_wstrb", wstrb, 8'h0F);
    tick();
    awready = 0;
    chk("ww_aw_drop", {awvalid, wvalid, bready}, 3'b010);
    tick();
    tick();
    chk("ww_w_hold", {wvalid, bready}, 2'b10);
    wready = 1;
    bready_cycles = 0;
    tick();
    wready = 0;
    chk("ww_wresp", {wvalid, bready}, 2'b01);
    if (bready) bready_cycles++;
    bvalid = 1; bresp = 2'b10;
    tick();
    bvalid = 0; bresp = 2'b00;
    if (bready) bready_cycles++;
    chk("ww_rv", rv, 1'b1);
    chk("ww_err", err, 1'b1);
    chk("ww_rdata0", srdata, 64'h0);
    tick();
    if (bready) bready_cycles++;
    chk("ww_single_wresp", bready_cycles, 1);
    chk("ww_rv_pulse", {rv, err}, 2'b01);

`ifdef SRI_TO_AXILITE_TIMEOUT_EN
    // Stalled read: 16 busy cycles then an error response
    en = 1; we = 0; addr = 20'h8;
    tick();
    en = 0;
    n = 1;
    while (!rv && n < 40) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, 17);
    chk("tmo_err", err, 1'b1);
    chk("tmo_rdata", srdata, 64'h0);
    chk("tmo_drop", {arvalid, rready}, 2'b00);
    tick();
`endif

    // Reset in the middle of a read
    en = 1; we = 0; addr = 20'h30;
    tick();
    en = 0;
    tick();
    chk("mid_arvalid", arvalid, 1'b1);
    rstn = 0;
    #1;
    chk("mid_rst_outputs", any_out(), 1'b0);
    @(negedge clk);
    rstn = 1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      seen = seen | rv | busy;
    end
    chk("mid_no_resp", seen, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
